alarm_clk_avmm_master: RTL



---
 rtl/alarm_clk_avmm_master.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alarm_clk_avmm_master.sv
// Single-outstanding Avalon-MM initiator for the alarm_clk PIO slaves.
// Turns a valid/ready command stream into one bus access at a time, with a waitrequest timeout.
module alarm_clk_avmm_master #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic               cs_nxt, write_n_nxt, read_n_nxt;
    logic               rsp_valid_nxt, rsp_error_nxt;
    logic [DATA_W-1:0]  rsp_readdata_nxt;

    // Stall counter saturates so it can never wrap when the timeout is disabled.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cmd_ready = (state == IDLE) && !reset;

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        addr_nxt         = avm_address;
        wdata_nxt        = avm_writedata;
        cs_nxt           = avm_chipselect;
        write_n_nxt      = avm_write_n;
        read_n_nxt       = avm_read_n;
        rsp_valid_nxt    = 1'b0;
        rsp_readdata_nxt = rsp_readdata;
        rsp_error_nxt    = rsp_error;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_nxt    = cmd_address;
                    wdata_nxt   = cmd_writedata;
                    cs_nxt      = 1'b1;
                    write_n_nxt = !cmd_write;
                    read_n_nxt  = cmd_write;
                    cnt_nxt     = '0;
                    state_nxt   = ACCESS;
                end
            end
            ACCESS: begin
                if (!avm_waitrequest) begin
                    cs_nxt           = 1'b0;
                    write_n_nxt      = 1'b1;
                    read_n_nxt       = 1'b1;
                    rsp_readdata_nxt = avm_read_n ? '0 : avm_readdata;
                    rsp_error_nxt    = 1'b0;
                    rsp_valid_nxt    = 1'b1;
                    state_nxt        = RESP;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    cs_nxt           = 1'b0;
                    write_n_nxt      = 1'b1;
                    read_n_nxt       = 1'b1;
                    rsp_readdata_nxt = '0;
                    rsp_error_nxt    = 1'b1;
                    rsp_valid_nxt    = 1'b1;
                    state_nxt        = RESP;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_readdata   <= '0;
            rsp_error      <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            avm_address    <= addr_nxt;
            avm_writedata  <= wdata_nxt;
            avm_chipselect <= cs_nxt;
            avm_write_n    <= write_n_nxt;
            avm_read_n     <= read_n_nxt;
            rsp_valid      <= rsp_valid_nxt;
            rsp_readdata   <= rsp_readdata_nxt;
            rsp_error      <= rsp_error_nxt;
        end
    end

endmodule
